// File: rtl/alu_wb_pkg.sv
// Shared types and constants for the ALU writeback/status stage.
// Entry and pending-register layouts are sized by DATA_W/DEST_W.
package alu_wb_pkg;

    localparam int DATA_W     = 8;
    localparam int DEST_W     = 3;
    localparam int FLAG_WIDTH = 3;

    localparam int FLAG_C = 2;
    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    typedef struct packed {
        logic [DEST_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    typedef struct packed {
        logic              valid;
        logic [DEST_W-1:0] dest;
        logic              wb;
        logic              set_flags;
    } pending_t;

    function automatic wb_entry_t make_entry(input logic [DEST_W-1:0] dest,
                                             input logic [DATA_W-1:0] data);
        wb_entry_t e;
        e.dest = dest;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order synchronous FIFO for writeback entries; supports push and pop in one cycle.
// The head reads as zero while empty so the register-file bus is clean after reset.
module wb_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [CNT_W-1:0] count,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    always_comb begin
        pop_ok   = pop && (count_q != '0);
        push_ok  = push && ((count_q != DEPTH_C) || pop_ok);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        // Pointers wrap naturally because DEPTH is a power of two.
        if (push_ok) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clock) begin
        mem_q <= mem_d;
    end

    assign count = count_q;
    assign empty = (count_q == '0);
    assign head  = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/alu_writeback.sv
// Writeback/status stage behind the one-cycle ALU: holds the issued op for a cycle,
// captures result and flags, updates status and queues results for the register file.
module alu_writeback
    import alu_wb_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_W,
    parameter int DEST_WIDTH = DEST_W,
    parameter int DEPTH      = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [DEST_WIDTH-1:0] issue_dest,
    input  logic                  issue_wb,
    input  logic                  issue_set_flags,
    output logic                  issue_ready,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic [FLAG_WIDTH-1:0] alu_flags,
    input  logic                  flag_clear,
    output logic [FLAG_WIDTH-1:0] status,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [DEST_WIDTH-1:0] wb_dest,
    output logic [DATA_WIDTH-1:0] wb_data
);

    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

    pending_t              pend_q, pend_d;
    logic [FLAG_WIDTH-1:0] status_q, status_d;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_empty;
    wb_entry_t             fifo_head;
    wb_entry_t             push_entry;
    logic                  push;
    logic                  pop;
    logic [CNT_W:0]        occupancy;

    // A pending write-back already owns a slot; a same-cycle pop is deliberately not credited.
    always_comb begin
        occupancy   = {1'b0, fifo_count} + {{CNT_W{1'b0}}, (pend_q.valid & pend_q.wb)};
        issue_ready = (occupancy < DEPTH_C);
    end

    always_comb begin
        pend_d           = '0;
        pend_d.valid     = issue_valid & issue_ready;
        pend_d.dest      = issue_dest;
        pend_d.wb        = issue_wb;
        pend_d.set_flags = issue_set_flags;
    end

    always_comb begin
        status_d = status_q;
        if (pend_q.valid && pend_q.set_flags) begin
            status_d[FLAG_C] = alu_flags[FLAG_C];
            status_d[FLAG_N] = alu_flags[FLAG_N];
            status_d[FLAG_Z] = alu_flags[FLAG_Z];
        end else if (flag_clear) begin
            status_d = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pend_q   <= '0;
            status_q <= '0;
        end else begin
            pend_q   <= pend_d;
            status_q <= status_d;
        end
    end

    always_comb begin
        push       = pend_q.valid & pend_q.wb;
        push_entry = make_entry(pend_q.dest, alu_result);
        pop        = wb_valid & wb_ready;
    end

    wb_fifo #(
        .WIDTH($bits(wb_entry_t)),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_data(push_entry),
        .pop      (pop),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .head     (fifo_head)
    );

    assign status   = status_q;
    assign wb_valid = ~fifo_empty;
    assign wb_dest  = fifo_head.dest;
    assign wb_data  = fifo_head.data;

endmodule
